// File: rtl/alu_serial_seq_pkg.sv
// Shared encodings for the ALU family (serial sequencer, parallel ALU, decoder).
// Contents: op encodings OP_ADD..OP_OR, sequencer state encodings S_IDLE/S_RUN/S_DONE,
// and a helper that says whether an op uses the carry chain.
package alu_serial_seq_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_XOR  = 3'b010,
    OP_SLT  = 3'b011,
    OP_AND  = 3'b100,
    OP_NAND = 3'b101,
    OP_NOR  = 3'b110,
    OP_OR   = 3'b111
  } alu_op_e;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } seq_state_e;

  // Ops whose result comes from the adder (carry chain and overflow meaningful).
  function automatic logic op_is_arith(input alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // Ops that add the inverted B operand with an initial carry of one.
  function automatic logic op_is_sub(input alu_op_e op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_serial_seq_alu1bit.sv
// One-bit ALU slice used as the serial datapath of alu_serial_seq.
// Ports:
//   a, b  in  operand bits
//   cin   in  carry in (used by ADD/SUB/SLT only)
//   op    in  operation
//   y_c   out combinational result bit (sum bit for ADD/SUB/SLT)
//   cout_c out combinational carry out (0 for logical ops)
module alu_serial_seq_alu1bit
  import alu_serial_seq_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  logic    cin,
  input  alu_op_e op,
  output logic    y_c,
  output logic    cout_c
);

  logic w_b_eff;

  // SUB/SLT add the complement of b; the caller seeds cin=1 on the first bit.
  assign w_b_eff = op_is_sub(op) ? ~b : b;

  always_comb begin
    y_c    = 1'b0;
    cout_c = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_SLT: begin
        y_c    = a ^ w_b_eff ^ cin;
        cout_c = (a & w_b_eff) | (a & cin) | (w_b_eff & cin);
      end
      OP_XOR:  y_c = a ^ b;
      OP_AND:  y_c = a & b;
      OP_NAND: y_c = ~(a & b);
      OP_NOR:  y_c = ~(a | b);
      OP_OR:   y_c = a | b;
      default: y_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial WIDTH-bit ALU sequencer: drives one 1-bit slice LSB-first, one bit per clock,
// carrying the slice carry between bits and assembling the WIDTH-bit result.
// Optional flags are compiled in with the macro ALU_SERIAL_FLAGS_EN.
// Ports:
//   clk      in  rising-edge clock
//   reset    in  synchronous active-high reset
//   start    in  request, sampled only in IDLE
//   op       in  3-bit operation (see alu_serial_seq_pkg)
//   a, b     in  WIDTH-bit operands, captured with start
//   busy     out high while bits are being processed
//   done     out one-cycle pulse, result valid
//   result   out WIDTH-bit result, held until the next completed operation
//   zero     out [ALU_SERIAL_FLAGS_EN] result == 0
//   overflow out [ALU_SERIAL_FLAGS_EN] signed overflow (ADD/SUB/SLT)
//   carryout out [ALU_SERIAL_FLAGS_EN] carry out of MSB (ADD/SUB/SLT)
module alu_serial_seq
  import alu_serial_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef ALU_SERIAL_FLAGS_EN
  ,
  output logic             zero,
  output logic             overflow,
  output logic             carryout
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_res_sh;
  alu_op_e          r_op;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic             w_slice_y;
  logic             w_slice_cout;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_ovf;
  logic [WIDTH-1:0] w_result_final;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_run    = (r_state == S_RUN);
  assign w_last   = w_run && (r_cnt == CNT_LAST);

  // The single serial datapath slice.
  alu_serial_seq_alu1bit u_slice (
    .a      (r_a_sh[0]),
    .b      (r_b_sh[0]),
    .cin    (r_carry),
    .op     (r_op),
    .y_c    (w_slice_y),
    .cout_c (w_slice_cout)
  );

  // After the last bit this holds the complete shifted result, LSB from the first bit.
  assign w_res_nxt = {w_slice_y, r_res_sh};

  // On the last bit r_carry is the carry into the MSB and the slice cout the carry out of it.
  assign w_ovf = op_is_arith(r_op) ? (r_carry ^ w_slice_cout) : 1'b0;

  // SLT reduces to the corrected sign of a - b.
  assign w_result_final = (r_op == OP_SLT) ? {{(WIDTH-1){1'b0}}, w_slice_y ^ w_ovf} : w_res_nxt;

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sequencer next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, bit shifting and result assembly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_op     <= OP_ADD;
      r_carry  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a_sh   <= a;
        r_b_sh   <= b;
        r_op     <= alu_op_e'(op);
        r_cnt    <= '0;
        r_carry  <= op_is_sub(alu_op_e'(op));
        r_res_sh <= '0;
        r_busy   <= 1'b1;
      end else if (w_run) begin
        r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
        r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
        r_res_sh <= w_res_nxt[WIDTH-1:1];
        r_carry  <= w_slice_cout;
        r_cnt    <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_busy   <= 1'b0;
          r_result <= w_result_final;
        end
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

`ifdef ALU_SERIAL_FLAGS_EN
  logic r_zero;
  logic r_overflow;
  logic r_carryout;

  // Flags update together with the result and hold until the next completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_carryout <= 1'b0;
    end else if (w_last) begin
      r_zero     <= (w_result_final == '0);
      r_overflow <= w_ovf;
      r_carryout <= op_is_arith(r_op) ? w_slice_cout : 1'b0;
    end
  end

  assign zero     = r_zero;
  assign overflow = r_overflow;
  assign carryout = r_carryout;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq (WIDTH=8): directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_serial_seq;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
`ifdef ALU_SERIAL_FLAGS_EN
  logic         zero;
  logic         overflow;
  logic         carryout;
`endif

  int total = 0;
  int bad   = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result)
`ifdef ALU_SERIAL_FLAGS_EN
    ,
    .zero     (zero),
    .overflow (overflow),
    .carryout (carryout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {zero, overflow, carryout, result} from plain two's-complement arithmetic.
  function automatic logic [W+2:0] ref_model(input logic [2:0] f, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (f)
      3'b000: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[W-1:0]; c = s[W];
        v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
      end
      3'b001, 3'b011: begin
        s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        c = s[W];
        v = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
        if (f == 3'b001) r = s[W-1:0];
        else r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      end
      3'b010: r = x ^ y;
      3'b100: r = x & y;
      3'b101: r = ~(x & y);
      3'b110: r = ~(x | y);
      default: r = x | y;
    endcase
    return {(r == '0), v, c, r};
  endfunction

  // Issue one operation; optionally pulse a competing start at bit inj_bit.
  // Checks done timing, pulse count, busy, result and (if present) flags.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int inj_bit);
    logic [W+2:0] exp;
    int first_done;
    int n_done;
    logic busy_ok;
    exp = ref_model(f, x, y);
    @(negedge clk);
    start = 1'b1; op = f; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; op = $urandom_range(7, 0); a = W'($urandom); b = W'($urandom);
    first_done = -1; n_done = 0; busy_ok = 1'b1;
    for (int i = 1; i <= int'(W) + 3; i++) begin
      if (i - 1 == inj_bit) begin
        start = 1'b1; op = 3'b000; a = 8'hFF; b = 8'hFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (i < int'(W) && !busy) busy_ok = 1'b0;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = i;
      end
      if (i == int'(W)) begin
        check({tag, "_result"}, 32'(result), 32'(exp[W-1:0]));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
`ifdef ALU_SERIAL_FLAGS_EN
        check({tag, "_zero"}, 32'(zero), 32'(exp[W+2]));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp[W+1]));
        check({tag, "_cout"}, 32'(carryout), 32'(exp[W]));
`endif
      end
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 32'(first_done), 32'(W));
    check({tag, "_done_count"}, 32'(n_done), 32'd1);
    check({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
  endtask

  initial begin
    int n_done;
    logic [2:0]   rf;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("add_ovf", 3'b000, 8'h7F, 8'h01, -1);
    run_op("sub_zero", 3'b001, 8'h05, 8'h05, -1);
    run_op("slt_neg", 3'b011, 8'hFF, 8'h01, -1);
    run_op("slt_ovf0", 3'b011, 8'h7F, 8'h80, -1);
    run_op("slt_ovf1", 3'b011, 8'h80, 8'h7F, -1);
    run_op("xor", 3'b010, 8'hF0, 8'hCC, -1);
    run_op("and", 3'b100, 8'hF0, 8'hCC, -1);
    run_op("nand", 3'b101, 8'hF0, 8'hCC, -1);
    run_op("nor", 3'b110, 8'hF0, 8'hCC, -1);
    run_op("or", 3'b111, 8'hF0, 8'hCC, -1);
    run_op("busy_start", 3'b000, 8'h01, 8'h01, 3);

    // Abort an operation at bit 4 with reset.
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 8'h0F; b = 8'h01;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    n_done = 0;
    for (int i = 0; i < int'(W) + 2; i++) begin
      if (done) n_done++;
      @(posedge clk);
      #1;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    run_op("after_abort", 3'b000, 8'h0F, 8'h01, -1);

    // Randomized operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      rf = 3'($urandom_range(7, 0));
      ra = W'($urandom);
      rb = W'($urandom);
      run_op($sformatf("rand%0d_op%0d", k, rf), rf, ra, rb, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
